// File: rtl/vga_pkg.sv
// Shared widths, per-axis timing record and the two reference video modes.
package vga_pkg;
  localparam int CW_DEF = 12;
  localparam int DW_DEF = 16;

  typedef struct packed {
    logic [11:0] act;
    logic [11:0] fp;
    logic [11:0] sync;
    logic [11:0] tot;
    logic        pol;
  } axis_cfg_t;

  typedef struct packed {
    axis_cfg_t h;
    axis_cfg_t v;
  } mode_t;

  localparam mode_t MODE_1080P = '{
    '{12'd1920, 12'd2008, 12'd2052, 12'd2200, 1'b1},
    '{12'd1080, 12'd1084, 12'd1089, 12'd1125, 1'b1}};

  localparam mode_t MODE_960P = '{
    '{12'd1280, 12'd1360, 12'd1496, 12'd1712, 1'b0},
    '{12'd960,  12'd961,  12'd964,  12'd994,  1'b1}};
endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus active/sync decode.
module vga_axis_counter #(
  parameter int CW      = 12,
  parameter int RST_VAL = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          adv_i,
  input  logic [CW-1:0] act_i,
  input  logic [CW-1:0] fp_i,
  input  logic [CW-1:0] sync_i,
  input  logic [CW-1:0] tot_i,
  input  logic [CW-1:0] act_nxt_i,
  input  logic [CW-1:0] mask_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          act_o,
  output logic          sync_o,
  output logic          first_nxt_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  // >= keeps the counter bounded if it ever sits past the programmed total
  assign wrap_o = (cnt_q >= tot_i - CW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= CW'(RST_VAL);
    else         cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign act_o  = (cnt_q < act_i);
  assign sync_o = (cnt_q >= fp_i) && (cnt_q < sync_i);
  // Next position is active under the limit that will be in force next cycle
  // and starts a replication group.
  assign first_nxt_o = (cnt_d < act_nxt_i) && ((cnt_d & mask_i) == '0);
endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-programmable raster timing with frame-latched config and a
// replicating ready/valid pixel pull; all outputs registered one clock late.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int            CW         = CW_DEF,
  parameter int            DW         = DW_DEF,
  parameter int            H_ACT_DEF  = int'(MODE_1080P.h.act),
  parameter int            H_FP_DEF   = int'(MODE_1080P.h.fp),
  parameter int            H_SYNC_DEF = int'(MODE_1080P.h.sync),
  parameter int            H_TOT_DEF  = int'(MODE_1080P.h.tot),
  parameter int            V_ACT_DEF  = int'(MODE_1080P.v.act),
  parameter int            V_FP_DEF   = int'(MODE_1080P.v.fp),
  parameter int            V_SYNC_DEF = int'(MODE_1080P.v.sync),
  parameter int            V_TOT_DEF  = int'(MODE_1080P.v.tot),
  parameter bit            H_POL_DEF  = 1'b1,
  parameter bit            V_POL_DEF  = 1'b1,
  parameter logic [DW-1:0] UNDERFLOW_COLOR = DW'(16'hF81F)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] cfg_h_act,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_tot,
  input  logic [CW-1:0] cfg_v_act,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_tot,
  input  logic          cfg_h_pol,
  input  logic          cfg_v_pol,
  input  logic [1:0]    cfg_scale,
  input  logic [DW-1:0] pix_in_data,
  input  logic          pix_in_valid,
  output logic          pix_in_ready,
  input  logic          underflow_clr,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [DW-1:0] pixel_out,
  output logic [CW-1:0] x_src,
  output logic [CW-1:0] y_src,
  output logic          frame_start,
  output logic          underflow
);
  typedef struct packed {
    logic [CW-1:0] act;
    logic [CW-1:0] fp;
    logic [CW-1:0] sync;
    logic [CW-1:0] tot;
    logic          pol;
  } axis_t;

  localparam axis_t H_RST = '{CW'(H_ACT_DEF), CW'(H_FP_DEF), CW'(H_SYNC_DEF),
                              CW'(H_TOT_DEF), H_POL_DEF};
  localparam axis_t V_RST = '{CW'(V_ACT_DEF), CW'(V_FP_DEF), CW'(V_SYNC_DEF),
                              CW'(V_TOT_DEF), V_POL_DEF};

  axis_t         hs_q, hs_d, vs_q, vs_d;
  logic [1:0]    scale_q, scale_d;
  logic [CW-1:0] h_cnt, v_cnt, mask_d;
  logic          h_wrap, v_wrap, h_act, v_act, h_syn, v_syn;
  logic          h_first_nxt, v_act_nxt, last, active, miss;
  logic [DW-1:0] grp_pix;

  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic          fs_q, fs_d, ufl_q, ufl_d, rdy_q, rdy_d;
  logic [DW-1:0] pix_q, pix_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;

  assign last = h_wrap & v_wrap;

  // New timing takes effect only across the last clock of a frame.
  always_comb begin
    hs_d    = hs_q;
    vs_d    = vs_q;
    scale_d = scale_q;
    if (last) begin
      hs_d    = '{cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_tot, cfg_h_pol};
      vs_d    = '{cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_tot, cfg_v_pol};
      scale_d = cfg_scale;
    end
  end

  assign mask_d = ~({CW{1'b1}} << scale_d);

  vga_axis_counter #(.CW(CW), .RST_VAL(H_TOT_DEF - 1)) u_h (
    .clk_i(clk), .rst_ni(rst_n), .adv_i(1'b1),
    .act_i(hs_q.act), .fp_i(hs_q.fp), .sync_i(hs_q.sync), .tot_i(hs_q.tot),
    .act_nxt_i(hs_d.act), .mask_i(mask_d),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .act_o(h_act), .sync_o(h_syn),
    .first_nxt_o(h_first_nxt)
  );

  vga_axis_counter #(.CW(CW), .RST_VAL(V_TOT_DEF - 1)) u_v (
    .clk_i(clk), .rst_ni(rst_n), .adv_i(h_wrap),
    .act_i(vs_q.act), .fp_i(vs_q.fp), .sync_i(vs_q.sync), .tot_i(vs_q.tot),
    .act_nxt_i(vs_d.act), .mask_i('0),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .act_o(v_act), .sync_o(v_syn),
    .first_nxt_o(v_act_nxt)
  );

  assign active  = h_act & v_act;
  assign miss    = rdy_q & ~pix_in_valid;
  assign grp_pix = pix_in_valid ? pix_in_data : UNDERFLOW_COLOR;

  always_comb begin
    hsync_d = hs_q.pol ? h_syn : ~h_syn;
    vsync_d = vs_q.pol ? v_syn : ~v_syn;
    de_d    = active;
    fs_d    = (h_cnt == '0) && (v_cnt == '0);
    x_d     = h_cnt >> scale_q;
    y_d     = v_cnt >> scale_q;
    rdy_d   = h_first_nxt & v_act_nxt;
    ufl_d   = miss | (ufl_q & ~underflow_clr);
    // Within a group the previous output is the group's pixel, so it is held.
    pix_d   = '0;
    if (active) pix_d = rdy_q ? grp_pix : pix_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= H_RST;
      vs_q    <= V_RST;
      scale_q <= 2'd0;
      hsync_q <= ~H_POL_DEF;
      vsync_q <= ~V_POL_DEF;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rdy_q   <= 1'b0;
      ufl_q   <= 1'b0;
      pix_q   <= '0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      scale_q <= scale_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rdy_q   <= rdy_d;
      ufl_q   <= ufl_d;
      pix_q   <= pix_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign de           = de_q;
  assign frame_start  = fs_q;
  assign x_src        = x_q;
  assign y_src        = y_q;
  assign pix_in_ready = rdy_q;
  assign underflow    = ufl_q;
  assign pixel_out    = pix_q;
endmodule
